// File: rtl/mining_pkg.sv
// ============================================================================
// mining_pkg : shared types and constants for the nonce generator/checker path
// Revision   : 1.0
// ============================================================================
`default_nettype none

package mining_pkg;

   typedef enum logic [1:0] {
      INIT        = 2'd0,
      FETCH_NONCE = 2'd1,
      READ_HASH   = 2'd2,
      DECIDE      = 2'd3
   } chk_state_e;

   localparam int HASH_WORDS_DEF = 4;
   localparam int HASH_W         = 256;
   localparam int NONCE_W        = 32;
   localparam int WORD_W         = 64;

endpackage

`default_nettype wire

// File: rtl/nonce_checker_word_cmp.sv
// ============================================================================
// word_cmp : serial magnitude comparator, most-significant word first
// Revision : 1.0
// ============================================================================
`default_nettype none

module word_cmp #(
   parameter int WORD_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [WORD_W-1:0] word,
   input  logic [WORD_W-1:0] tgt,
   output logic              eq,
   output logic              lt,
   output logic              meet
);

   logic eq_q, eq_d;
   logic lt_q, lt_d;

   // Once a word differs the outcome is decided; later words cannot change it.
   always_comb begin
      eq_d = eq_q;
      lt_d = lt_q;
      if (clr) begin
         eq_d = 1'b1;
         lt_d = 1'b0;
      end else if (en && eq_q) begin
         if (word < tgt) begin
            lt_d = 1'b1;
            eq_d = 1'b0;
         end else if (word > tgt) begin
            eq_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eq_q <= 1'b0;
         lt_q <= 1'b0;
      end else begin
         eq_q <= eq_d;
         lt_q <= lt_d;
      end
   end

   assign eq   = eq_q;
   assign lt   = lt_q;
   assign meet = lt_q | eq_q;

endmodule

`default_nettype wire

// File: rtl/nonce_checker.sv
// ============================================================================
// nonce_checker : pairs hashes with nonces, forwards nonces whose hash <= target
// Revision      : 1.0
// ============================================================================
`default_nettype none

module nonce_checker
   import mining_pkg::*;
#(
   parameter int HASH_WORDS = HASH_WORDS_DEF,
   parameter int CNT_W      = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     stop,
   input  logic [HASH_WORDS*64-1:0] target,
   input  logic [63:0]              hashout_dout,
   input  logic                     hashout_empty,
   output logic                     hashout_re,
   input  logic [31:0]              nonce_fifo_dout,
   input  logic                     nonce_fifo_empty,
   output logic                     nonce_fifo_re,
   output logic [31:0]              golden_fifo_din,
   output logic                     golden_fifo_we,
   input  logic                     golden_fifo_full,
   output logic                     stop_ack_check,
   output logic [CNT_W-1:0]         hash_cnt,
   output logic [CNT_W-1:0]         golden_cnt
);

   localparam int TGT_W = HASH_WORDS * WORD_W;
   localparam int IDX_W = (HASH_WORDS > 1) ? $clog2(HASH_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HASH_WORDS - 1);

   chk_state_e         state_q, state_d;
   logic               stop_ack_q, stop_ack_d;
   logic [TGT_W-1:0]   target_q, target_d;
   logic [NONCE_W-1:0] nonce_q, nonce_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   hash_cnt_q, hash_cnt_d;
   logic [CNT_W-1:0]   golden_cnt_q, golden_cnt_d;
   logic               counted_q, counted_d;

   logic [WORD_W-1:0]  tgt_word;
   logic               cmp_clr, cmp_en, cmp_eq, cmp_lt, meet;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      tgt_word = '0;
      for (int k = 0; k < HASH_WORDS; k++) begin
         if (cnt_q == IDX_W'(k)) tgt_word = target_q[TGT_W-1-k*WORD_W -: WORD_W];
      end
   end

   word_cmp #(.WORD_W(WORD_W)) u_cmp (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (cmp_clr),
      .en   (cmp_en),
      .word (hashout_dout),
      .tgt  (tgt_word),
      .eq   (cmp_eq),
      .lt   (cmp_lt),
      .meet (meet)
   );

   always_comb begin
      state_d         = state_q;
      stop_ack_d      = stop_ack_q;
      target_d        = target_q;
      nonce_d         = nonce_q;
      cnt_d           = cnt_q;
      hash_cnt_d      = hash_cnt_q;
      golden_cnt_d    = golden_cnt_q;
      counted_d       = counted_q;
      hashout_re      = 1'b0;
      nonce_fifo_re   = 1'b0;
      golden_fifo_we  = 1'b0;
      golden_fifo_din = '0;
      cmp_clr         = 1'b0;
      cmp_en          = 1'b0;
      case (state_q)
         INIT: begin
            stop_ack_d = 1'b1;
            if (start) begin
               target_d     = target;
               hash_cnt_d   = '0;
               golden_cnt_d = '0;
               state_d      = FETCH_NONCE;
            end
         end
         FETCH_NONCE: begin
            stop_ack_d = 1'b0;
            if (stop) begin
               state_d = INIT;
            end else if (!nonce_fifo_empty) begin
               nonce_fifo_re = 1'b1;
               nonce_d       = nonce_fifo_dout;
               cnt_d         = '0;
               cmp_clr       = 1'b1;
               state_d       = READ_HASH;
            end
         end
         // stop is deliberately not looked at here: a popped nonce always gets its verdict.
         READ_HASH: begin
            if (!hashout_empty) begin
               hashout_re = 1'b1;
               cmp_en     = 1'b1;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = DECIDE;
               end
            end
         end
         DECIDE: begin
            if (!counted_q) begin
               hash_cnt_d = sat_inc(hash_cnt_q);
               counted_d  = 1'b1;
            end
            if (!meet) begin
               counted_d = 1'b0;
               state_d   = FETCH_NONCE;
            end else if (!golden_fifo_full) begin
               golden_fifo_we  = 1'b1;
               golden_fifo_din = nonce_q;
               golden_cnt_d    = sat_inc(golden_cnt_q);
               counted_d       = 1'b0;
               state_d         = FETCH_NONCE;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= INIT;
         stop_ack_q   <= 1'b0;
         target_q     <= '0;
         nonce_q      <= '0;
         cnt_q        <= '0;
         hash_cnt_q   <= '0;
         golden_cnt_q <= '0;
         counted_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         stop_ack_q   <= stop_ack_d;
         target_q     <= target_d;
         nonce_q      <= nonce_d;
         cnt_q        <= cnt_d;
         hash_cnt_q   <= hash_cnt_d;
         golden_cnt_q <= golden_cnt_d;
         counted_q    <= counted_d;
      end
   end

   assign stop_ack_check = stop_ack_q;
   assign hash_cnt       = hash_cnt_q;
   assign golden_cnt     = golden_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_nonce_checker.sv
// ============================================================================
// tb_nonce_checker : scoreboard bench for nonce_checker with FWFT FIFO models
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_nonce_checker;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, stop;
   logic [255:0] target;
   logic [63:0]  hashout_dout;
   logic         hashout_empty, hashout_re;
   logic [31:0]  nonce_fifo_dout;
   logic         nonce_fifo_empty, nonce_fifo_re;
   logic [31:0]  golden_fifo_din;
   logic         golden_fifo_we, golden_fifo_full;
   logic         stop_ack_check;
   logic [31:0]  hash_cnt, golden_cnt;

   nonce_checker #(.HASH_WORDS(4), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .target(target),
      .hashout_dout(hashout_dout), .hashout_empty(hashout_empty), .hashout_re(hashout_re),
      .nonce_fifo_dout(nonce_fifo_dout), .nonce_fifo_empty(nonce_fifo_empty),
      .nonce_fifo_re(nonce_fifo_re), .golden_fifo_din(golden_fifo_din),
      .golden_fifo_we(golden_fifo_we), .golden_fifo_full(golden_fifo_full),
      .stop_ack_check(stop_ack_check), .hash_cnt(hash_cnt), .golden_cnt(golden_cnt)
   );

   always #5 clk = ~clk;

   logic [63:0]  hq[$];
   logic [31:0]  nq[$];
   logic [31:0]  sb[$];
   logic [255:0] cur_tgt;
   int           vectors = 0, miscompares = 0;
   int           hpops = 0, npops = 0, wr_cnt = 0;
   logic         rand_gaps = 1'b0, full_force = 1'b0;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock: present FIFO heads at negedge, then account for the strobes the DUT raises.
   task automatic cycle();
      logic [63:0] hw;
      logic [31:0] nw, gw;
      @(negedge clk);
      hashout_empty    = (hq.size() == 0) || (rand_gaps && $urandom_range(0, 2) == 0);
      hashout_dout     = (hq.size() != 0) ? hq[0] : 64'h0;
      nonce_fifo_empty = (nq.size() == 0) || (rand_gaps && $urandom_range(0, 2) == 0);
      nonce_fifo_dout  = (nq.size() != 0) ? nq[0] : 32'h0;
      golden_fifo_full = rand_gaps ? ($urandom_range(0, 3) == 0) : full_force;
      #1;
      if (hashout_re) begin
         if (hashout_empty) chk("hash_pop_on_empty", 256'(hashout_empty), 256'(0));
         else begin hw = hq.pop_front(); hpops++; end
      end
      if (nonce_fifo_re) begin
         if (nonce_fifo_empty) chk("nonce_pop_on_empty", 256'(nonce_fifo_empty), 256'(0));
         else begin nw = nq.pop_front(); npops++; end
      end
      if (golden_fifo_we) begin
         wr_cnt++;
         if (golden_fifo_full) chk("write_while_full", 256'(golden_fifo_full), 256'(0));
         if (sb.size() == 0) chk("unexpected_golden_we", 256'(golden_fifo_we), 256'(0));
         else begin gw = sb.pop_front(); chk("golden_din", 256'(golden_fifo_din), 256'(gw)); end
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic push_hash(input logic [255:0] h, input logic [31:0] n);
      for (int w = 0; w < 4; w++) hq.push_back(h[255-64*w -: 64]);
      nq.push_back(n);
      if (h <= cur_tgt) sb.push_back(n);
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && (hq.size() != 0 || nq.size() != 0); i++) cycle();
      chk("drain_hash_left", 256'(hq.size()), 256'(0));
      chk("drain_nonce_left", 256'(nq.size()), 256'(0));
      cycles(8);
   endtask

   task automatic new_run(input logic [255:0] tgt);
      stop = 1'b1;
      for (int i = 0; i < 40 && !stop_ack_check; i++) cycle();
      chk("idle_ack", 256'(stop_ack_check), 256'(1));
      stop    = 1'b0;
      target  = tgt;
      cur_tgt = tgt;
      start   = 1'b1;
      cycle();
      start   = 1'b0;
      wr_cnt  = 0;
   endtask

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [255:0] t1, h;
      int           h0, n0, exp_g;
      logic         saw_low;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; target = '0;
      hashout_empty = 1'b1; hashout_dout = '0;
      nonce_fifo_empty = 1'b1; nonce_fifo_dout = '0; golden_fifo_full = 1'b0;
      #2;
      chk("rst_ack", 256'(stop_ack_check), 256'(0));
      chk("rst_hash_cnt", 256'(hash_cnt), 256'(0));
      chk("rst_golden_cnt", 256'(golden_cnt), 256'(0));
      chk("rst_we", 256'(golden_fifo_we), 256'(0));
      chk("rst_din", 256'(golden_fifo_din), 256'(0));
      chk("rst_hre", 256'(hashout_re), 256'(0));
      chk("rst_nre", 256'(nonce_fifo_re), 256'(0));
      @(negedge clk); rst_n = 1'b1;
      cycle();
      chk("ack_after_rst", 256'(stop_ack_check), 256'(1));

      // Single pass
      t1 = {32'h0000FFFF, 224'h0};
      new_run(t1);
      push_hash({64'h00000000_12345678, 192'h0}, 32'hDEADBEEF);
      drain(100);
      chk("pass_hash_cnt", 256'(hash_cnt), 256'(1));
      chk("pass_golden_cnt", 256'(golden_cnt), 256'(1));
      chk("pass_writes", 256'(wr_cnt), 256'(1));

      // Fail on first word
      new_run(t1);
      push_hash({64'hFFFFFFFF_FFFFFFFF, 192'h0}, 32'h0BADF00D);
      drain(100);
      chk("fail_hash_cnt", 256'(hash_cnt), 256'(1));
      chk("fail_golden_cnt", 256'(golden_cnt), 256'(0));

      // Equality passes; one above target in the last word does not
      new_run(t1);
      push_hash(t1, 32'h00000042);
      push_hash(t1 + 256'd1, 32'h00000043);
      drain(100);
      chk("eq_hash_cnt", 256'(hash_cnt), 256'(2));
      chk("eq_golden_cnt", 256'(golden_cnt), 256'(1));
      chk("eq_writes", 256'(wr_cnt), 256'(1));

      // Golden FIFO full stall
      new_run(t1);
      full_force = 1'b1;
      push_hash({64'h1, 192'h0}, 32'hCAFE0001);
      cycles(12);
      chk("stall_hash_cnt", 256'(hash_cnt), 256'(1));
      chk("stall_golden_cnt", 256'(golden_cnt), 256'(0));
      chk("stall_writes", 256'(wr_cnt), 256'(0));
      full_force = 1'b0;
      cycles(4);
      chk("unstall_writes", 256'(wr_cnt), 256'(1));
      chk("unstall_hash_cnt", 256'(hash_cnt), 256'(1));
      chk("unstall_golden_cnt", 256'(golden_cnt), 256'(1));

      // Stop during the second hash word: hash still completes
      new_run(t1);
      h = {64'h2, 192'h5};
      h0 = hpops;
      nq.push_back(32'h51515151); hq.push_back(h[255:192]); sb.push_back(32'h51515151);
      for (int i = 0; i < 20 && hpops == h0; i++) cycle();
      stop = 1'b1;
      hq.push_back(h[191:128]); hq.push_back(h[127:64]); hq.push_back(h[63:0]);
      for (int i = 0; i < 40 && !stop_ack_check; i++) cycle();
      chk("stop_ack", 256'(stop_ack_check), 256'(1));
      chk("stop_words_left", 256'(hq.size()), 256'(0));
      chk("stop_hash_cnt", 256'(hash_cnt), 256'(1));
      chk("stop_writes", 256'(wr_cnt), 256'(1));
      stop = 1'b0;

      // start and stop together: start wins, stop returns to INIT without a pop
      nq.push_back(32'h77777777);
      start = 1'b1; stop = 1'b1; target = t1;
      cycle();
      start = 1'b0;
      saw_low = 1'b0;
      for (int i = 0; i < 6; i++) begin cycle(); if (!stop_ack_check) saw_low = 1'b1; end
      stop = 1'b0;
      chk("ss_ack_dipped", 256'(saw_low), 256'(1));
      chk("ss_ack", 256'(stop_ack_check), 256'(1));
      chk("ss_no_pop", 256'(nq.size()), 256'(1));
      chk("ss_hash_cnt", 256'(hash_cnt), 256'(0));
      nq.delete();

      // Streaming with random FIFO gaps and golden-full back-pressure
      t1 = {64'h00008000_00000000, rnd256() >> 64};
      new_run(t1);
      h0 = hpops; n0 = npops;
      for (int i = 0; i < 100; i++) begin
         h = rnd256();
         h[255:192] = t1[255:192] + 64'($urandom_range(0, 2)) - 64'd1;
         if (i % 10 == 0) h = t1;
         push_hash(h, $urandom);
      end
      exp_g = sb.size();
      rand_gaps = 1'b1;
      for (int i = 0; i < 4000 && (hq.size() != 0 || nq.size() != 0); i++) cycle();
      rand_gaps = 1'b0;
      drain(10);
      chk("stream_nonce_pops", 256'(npops - n0), 256'(100));
      chk("stream_ratio", 256'(hpops - h0), 256'(4 * (npops - n0)));
      chk("stream_hash_cnt", 256'(hash_cnt), 256'(100));
      chk("stream_golden_cnt", 256'(golden_cnt), 256'(exp_g));
      chk("stream_writes", 256'(wr_cnt), 256'(exp_g));
      chk("stream_sb_left", 256'(sb.size()), 256'(0));

      // Asynchronous reset in the middle of a hash
      h0 = hpops;
      push_hash({64'h0, 192'h1}, 32'h12121212);
      for (int i = 0; i < 20 && hpops < h0 + 2; i++) cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_hre", 256'(hashout_re), 256'(0));
      chk("arst_nre", 256'(nonce_fifo_re), 256'(0));
      chk("arst_we", 256'(golden_fifo_we), 256'(0));
      chk("arst_din", 256'(golden_fifo_din), 256'(0));
      chk("arst_ack", 256'(stop_ack_check), 256'(0));
      chk("arst_hash_cnt", 256'(hash_cnt), 256'(0));
      chk("arst_golden_cnt", 256'(golden_cnt), 256'(0));
      hq.delete(); nq.delete(); sb.delete();
      @(negedge clk); rst_n = 1'b1;
      cycles(2);
      chk("arst_ack_back", 256'(stop_ack_check), 256'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nonce_checker.md
Name: nonce_checker

Overview:
- Downstream stage of the nonce generator, fed through the SHA-256d core.
- Pairs each 256-bit hash result from the hashout FIFO with its nonce from the nonce FIFO, in FIFO order.
- Compares each hash against a software-supplied target and pushes qualifying ("golden") nonces into the golden FIFO for host readback.
- Keeps hash and golden counters for software progress monitoring.

Parameters:
- HASH_WORDS, 4, number of 64-bit hashout words per hash (HASH_WORDS*64 = 256).
- CNT_W, 32, width of the hash_cnt and golden_cnt counters.

Ports:
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a checking run; target latched on the same cycle
- stop  in  1  request to end the run
- target  in  256  difficulty target, sampled only in INIT when start=1
- hashout_dout  in  64  hashout FIFO data, FWFT, most-significant word first
- hashout_empty  in  1  hashout FIFO empty
- hashout_re  out  1  hashout FIFO pop
- nonce_fifo_dout  in  32  nonce FIFO data, FWFT
- nonce_fifo_empty  in  1  nonce FIFO empty
- nonce_fifo_re  out  1  nonce FIFO pop
- golden_fifo_din  out  32  golden nonce
- golden_fifo_we  out  1  golden FIFO write
- golden_fifo_full  in  1  golden FIFO full
- stop_ack_check  out  1  idle, ready for start
- hash_cnt  out  CNT_W  hashes checked in the current run
- golden_cnt  out  CNT_W  golden nonces written in the current run

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, stop_ack_check=0 (registered; becomes 1 one cycle after entering INIT).
  - Counters, target_reg and nonce_reg = 0.
  - All FIFO strobes 0; golden_fifo_din=0.
- FIFO strobes and golden_fifo_din are combinational from state and registers; they are 0 whenever not asserted.
- INIT:
  - stop_ack_check<=1.
  - If start: target_reg<=target, hash_cnt<=0, golden_cnt<=0, go to FETCH_NONCE.
- FETCH_NONCE:
  - stop_ack_check<=0.
  - If stop: go to INIT, no pop.
  - Else if !nonce_fifo_empty: nonce_fifo_re=1, nonce_reg<=nonce_fifo_dout, cnt<=0, eq<=1, lt<=0, go to READ_HASH.
- READ_HASH:
  - stop is ignored; a hash in progress always completes.
  - If !hashout_empty: hashout_re=1; compare hashout_dout with target_reg word cnt (word 0 = bits 255:192).
  - Compare rule: if eq and word<t then lt<=1, eq<=0; if eq and word>t then eq<=0; otherwise flags hold.
  - cnt<=cnt+1. On the pop with cnt=HASH_WORDS-1, go to DECIDE.
  - If empty, wait with no strobes.
- DECIDE:
  - hash_cnt<=hash_cnt+1, done once on entry via a one-shot flag.
  - meet = lt|eq, i.e. hash <= target. Equality counts as a pass.
  - If !meet: go to FETCH_NONCE.
  - If meet and !golden_fifo_full: golden_fifo_we=1, golden_fifo_din=nonce_reg, golden_cnt<=golden_cnt+1, go to FETCH_NONCE.
  - If meet and full: stall in DECIDE, no drop, hash_cnt not re-incremented.
- Throughput: best case one hash per HASH_WORDS+2 cycles.
- Counters saturate at all-ones and do not wrap.
- Simultaneous start and stop in INIT: start wins; stop is then seen in FETCH_NONCE on the next cycle, returning to INIT.
- Nonce present but hashout empty: the nonce is popped and held; the block waits for hash words.
- Pairing invariant: exactly one nonce pop per HASH_WORDS hashout pops.
- Reset mid-hash returns to INIT immediately. Partial FIFO contents are flushed externally by the top level.
- Illegal state: go to INIT.

Decomposition:
- Package mining_pkg holds:
  - checker state enum {INIT, FETCH_NONCE, READ_HASH, DECIDE};
  - HASH_WORDS default;
  - HASH_W=256 and NONCE_W=32 constants, shared with the nonce generator.
- Sub-module word_cmp: serial 64-bit magnitude comparator holding the eq/lt flags, with clear and enable inputs and a meet output.

Test Plan:
- Single pass:
  - Stimulus: target=0x0000_FFFF<<224, hash words {0x00000000_12345678, 0, 0, 0}, nonce 0xDEADBEEF.
  - Response: golden_fifo_we one cycle with din 0xDEADBEEF; hash_cnt=1, golden_cnt=1.
- Fail on first word: hash word0=0xFFFFFFFF_FFFFFFFF, same target → no golden write; hash_cnt=1.
- Equality:
  - Hash equal to target in all 4 words, nonce 0x00000042 → golden write, din 0x00000042.
  - Hash = target+1 in word 3 → no write.
- Golden full stall:
  - Stimulus: passing hash with golden_fifo_full=1 for 5 cycles.
  - Response: stays in DECIDE, we=0; after full drops, exactly one write; hash_cnt incremented once.
- Stop behaviour:
  - stop asserted during READ_HASH word 1 → all 4 words consumed, decision made, then INIT; stop_ack_check=1 one cycle later.
  - start&&stop together in INIT → FETCH_NONCE, then INIT.
- Streaming and reset:
  - 100 back-to-back hashes with random FIFO empty gaps → pop ratio 1 nonce : 4 hash words.
  - Golden set matches a reference-model compare.
  - rst_n low mid-run → all outputs zero immediately, asynchronously.
